// File: rtl/bcd_pkg.sv
// bcd_pkg
// Shared definitions for the packed-BCD arithmetic blocks: digit width,
// radix constants, the single-digit type and the serial subtractor's
// state encoding.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX     = 9;
  localparam int BCD_RADIX   = 10;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// bcd_digit_sub
// Combinational single-digit BCD subtract: d = x - y - bi, folded back into
// the 0..9 range when the difference goes negative.
// Ports:
//   x   : minuend digit
//   y   : subtrahend digit
//   bi  : borrow in
//   d   : result digit (truncated to 4 bits)
//   bo  : borrow out
//   bad : either operand digit is above 9
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t x,
  input  bcd_digit_t y,
  input  logic       bi,
  output bcd_digit_t d,
  output logic       bo,
  output logic       bad
);

  logic [4:0] diff_raw;
  bcd_digit_t diff_adj;

  // Zero-extended 5-bit difference; the range -16..15 fits exactly, so
  // bit 4 is the sign and doubles as the borrow out.
  assign diff_raw = {1'b0, x} - {1'b0, y} - {4'b0000, bi};
  assign bo       = diff_raw[4];

  // Adding the radix modulo 16 equals adding it to the full value and
  // keeping the low nibble.
  assign diff_adj = diff_raw[3:0] + bcd_digit_t'(BCD_RADIX);
  assign d        = bo ? diff_adj : diff_raw[3:0];

  assign bad = (x > bcd_digit_t'(BCD_MAX)) || (y > bcd_digit_t'(BCD_MAX));

endmodule

// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor
// Multi-digit packed-BCD subtractor computing a - b - bin one digit per
// clock, least-significant digit first, with a start/done handshake.
// Operands are captured when start is accepted.
// Optional feature macro: BCD_SIGN_MAG_EN
//   defined   : a negative result is converted to sign-magnitude in a
//               second pass (state FIX) and neg is raised.
//   undefined : negative results stay in tens-complement, neg is tied 0.
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : request, accepted in IDLE or DONE
//   a, b    : minuend / subtrahend, packed BCD, digit 0 in bits [3:0]
//   bin     : borrow in to digit 0
//   busy    : operation in progress
//   done    : one-cycle pulse when results are valid
//   diff    : result digits
//   bout    : borrow out of the most-significant digit
//   neg     : result is negative (sign-magnitude mode only)
//   invalid : an operand digit above 9 was seen in this operation
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  bout,
  output logic                  neg,
  output logic                  invalid
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t           state;
  bcd_digit_t       a_dig [DIGITS];
  bcd_digit_t       b_dig [DIGITS];
  bcd_digit_t       d_dig [DIGITS];
  logic [IDX_W-1:0] idx;
  logic             borrow;

  bcd_digit_t sub_x;
  bcd_digit_t sub_y;
  bcd_digit_t sub_d;
  logic       sub_bo;
  logic       sub_bad;

  for (genvar g = 0; g < DIGITS; g++) begin : g_diff
    assign diff[4*g +: 4] = d_dig[g];
  end

  // One digit slice serves both passes: CALC subtracts the operands, FIX
  // subtracts the stored result from zero to obtain its magnitude.
  assign sub_x = (state == FIX) ? '0        : a_dig[idx];
  assign sub_y = (state == FIX) ? d_dig[idx] : b_dig[idx];

  bcd_digit_sub u_digit (
    .x   (sub_x),
    .y   (sub_y),
    .bi  (borrow),
    .d   (sub_d),
    .bo  (sub_bo),
    .bad (sub_bad)
  );

`ifndef BCD_SIGN_MAG_EN
  assign neg = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bout    <= 1'b0;
      invalid <= 1'b0;
`ifdef BCD_SIGN_MAG_EN
      neg     <= 1'b0;
`endif
      idx     <= '0;
      borrow  <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        a_dig[i] <= '0;
        b_dig[i] <= '0;
        d_dig[i] <= '0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            for (int i = 0; i < DIGITS; i++) begin
              a_dig[i] <= a[4*i +: 4];
              b_dig[i] <= b[4*i +: 4];
              d_dig[i] <= '0;
            end
            invalid <= 1'b0;
`ifdef BCD_SIGN_MAG_EN
            neg     <= 1'b0;
`endif
            borrow  <= bin;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= CALC;
          end else begin
            state <= IDLE;
          end
        end

        CALC: begin
          d_dig[idx] <= sub_d;
          borrow     <= sub_bo;
          if (sub_bad) begin
            invalid <= 1'b1;
          end
          if (idx == LAST_IDX) begin
            bout <= sub_bo;
            idx  <= '0;
`ifdef BCD_SIGN_MAG_EN
            if (sub_bo) begin
              // The magnitude pass starts with no borrow.
              borrow <= 1'b0;
              state  <= FIX;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
`else
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end

`ifdef BCD_SIGN_MAG_EN
        FIX: begin
          d_dig[idx] <= sub_d;
          borrow     <= sub_bo;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            neg   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
`endif

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// tb_bcd_serial_subtractor
// Self-checking bench for bcd_serial_subtractor with DIGITS=4. Expected
// results come from a decimal-value reference model (with a digit-wise
// fallback for operands holding digits above 9). Honours BCD_SIGN_MAG_EN.
module tb_bcd_serial_subtractor;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         neg;
  logic         invalid;

  int tests = 0;
  int fails = 0;
  bit sm;

  bcd_serial_subtractor #(.DIGITS(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .diff    (diff),
    .bout    (bout),
    .neg     (neg),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: for all-valid operands the answer is plain decimal
  // arithmetic on the operand values; otherwise apply the digit rule.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic mbin,
                                output logic [W-1:0] md, output logic mbo,
                                output logic mneg, output logic minv,
                                output int mlat);
    longint va;
    longint vb;
    longint r;
    longint p;
    int     ad;
    int     bd;
    int     t;
    int     br;
    bit     bad;
    va = 0; vb = 0; p = 1; bad = 0; md = '0; mneg = 1'b0;
    for (int i = 0; i < D; i++) begin
      ad = int'(ma[4*i +: 4]);
      bd = int'(mb[4*i +: 4]);
      if (ad > 9 || bd > 9) bad = 1;
      va += ad * p;
      vb += bd * p;
      p  *= 10;
    end
    minv = bad;
    if (!bad) begin
      r   = va - vb - longint'(mbin);
      mbo = (r < 0);
      if (r < 0) begin
        if (sm) begin
          r    = -r;
          mneg = 1'b1;
        end else begin
          r += p;
        end
      end
      for (int i = 0; i < D; i++) begin
        md[4*i +: 4] = 4'(r % 10);
        r /= 10;
      end
    end else begin
      br = int'(mbin);
      for (int i = 0; i < D; i++) begin
        t  = int'(ma[4*i +: 4]) - int'(mb[4*i +: 4]) - br;
        br = (t < 0) ? 1 : 0;
        if (t < 0) t += 10;
        md[4*i +: 4] = 4'(t);
      end
      mbo = br[0];
      if (sm && br != 0) begin
        br = 0;
        for (int i = 0; i < D; i++) begin
          t  = 0 - int'(md[4*i +: 4]) - br;
          br = (t < 0) ? 1 : 0;
          if (t < 0) t += 10;
          md[4*i +: 4] = 4'(t);
        end
        mneg = 1'b1;
      end
    end
    mlat = (sm && mbo) ? 2 * D + 1 : D + 1;
  endfunction

  function automatic logic [W-1:0] randBcd(input bit allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < D; i++) begin
      if (allow_bad && $urandom_range(7, 0) == 0) v[4*i +: 4] = 4'($urandom_range(15, 10));
      else v[4*i +: 4] = 4'($urandom_range(9, 0));
    end
    return v;
  endfunction

  // Called at a falling edge; returns at the falling edge of cycle 1.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
    a     = ta;
    b     = tb_v;
    bin   = tbin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bin   = 1'($urandom);
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tbin, input bit inject, input bit check_idle);
    logic [W-1:0] md;
    logic         mbo;
    logic         mneg;
    logic         minv;
    int           mlat;
    int           n;
    bit           seen;
    bit           busy_ok;
    model(ta, tb_v, tbin, md, mbo, mneg, minv, mlat);
    applyStimulus(ta, tb_v, tbin);
    n = 1; seen = 0; busy_ok = 1;
    while (n <= 4 * D + 8) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (!busy) busy_ok = 0;
      if (inject && (n == 2 || n == 3)) begin
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checkOutput({tag, "_latency"}, 64'(seen ? n : 0), 64'(mlat));
    checkOutput({tag, "_busy_window"}, 64'(busy_ok), 64'(1));
    checkOutput({tag, "_busy_in_done"}, 64'(busy), 64'(0));
    checkOutput({tag, "_diff"}, 64'(diff), 64'(md));
    checkOutput({tag, "_bout"}, 64'(bout), 64'(mbo));
    checkOutput({tag, "_neg"}, 64'(neg), 64'(mneg));
    checkOutput({tag, "_invalid"}, 64'(invalid), 64'(minv));
    if (check_idle) begin
      @(negedge clk);
      checkOutput({tag, "_done_single"}, 64'(done), 64'(0));
      checkOutput({tag, "_idle_busy"}, 64'(busy), 64'(0));
      checkOutput({tag, "_diff_hold"}, 64'(diff), 64'(md));
    end
  endtask

  initial begin
    int  n_rand;
    bit  seen;
`ifdef BCD_SIGN_MAG_EN
    sm = 1'b1;
`else
    sm = 1'b0;
`endif

    // Reset state.
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_done", 64'(done), 64'(0));
    checkOutput("reset_diff", 64'(diff), 64'(0));
    checkOutput("reset_bout", 64'(bout), 64'(0));
    checkOutput("reset_neg", 64'(neg), 64'(0));
    checkOutput("reset_invalid", 64'(invalid), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    runOp("basic", 16'h1234, 16'h0567, 1'b0, 1'b0, 1'b1);
    runOp("negative", 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1);
    runOp("all_nines", 16'h9999, 16'h9999, 1'b1, 1'b0, 1'b0);
    runOp("back_to_back", 16'h5000, 16'h0001, 1'b0, 1'b0, 1'b1);
    runOp("bad_digit", 16'h00A0, 16'h0000, 1'b0, 1'b0, 1'b1);
    runOp("after_bad", 16'h0010, 16'h0005, 1'b0, 1'b0, 1'b1);
    runOp("start_ignored", 16'h4321, 16'h1234, 1'b0, 1'b1, 1'b1);
    runOp("zero_bin", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Reset in cycle 2 of a running operation.
    applyStimulus(16'h8765, 16'h1234, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", 64'(busy), 64'(0));
    checkOutput("midreset_done", 64'(done), 64'(0));
    checkOutput("midreset_diff", 64'(diff), 64'(0));
    checkOutput("midreset_bout", 64'(bout), 64'(0));
    checkOutput("midreset_neg", 64'(neg), 64'(0));
    checkOutput("midreset_invalid", 64'(invalid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 3 * D; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    checkOutput("midreset_no_done", 64'(seen), 64'(0));

    // Randomized operations, some started in the DONE cycle of the previous.
    n_rand = 24;
    for (int k = 0; k < n_rand; k++) begin
      runOp($sformatf("rand%0d", k), randBcd(1'b1), randBcd(1'b1), 1'($urandom),
            1'b0, (k % 4 != 3) || (k == n_rand - 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_serial_subtractor.md
Name: bcd_serial_subtractor

Overview:
- Multi-digit packed-BCD subtractor: computes a - b - bin one decimal digit per clock, least-significant digit first.
- Inverse operation of the team's combinational BCD digit adder.
- Used by the BCD calculator datapath for decrement and compare operations.
- Start/done handshake. Operands are captured at start, so upstream may change them immediately afterwards.

Parameters:
- DIGITS, 4, number of BCD digits per operand (1..16).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only in IDLE or DONE.
- a  input  4*DIGITS  minuend, packed BCD; digit 0 in bits [3:0].
- b  input  4*DIGITS  subtrahend, packed BCD.
- bin  input  1  borrow in, applied to digit 0.
- busy  output  1  high while an operation is in progress (CALC/FIX).
- done  output  1  one-cycle pulse when results are valid.
- diff  output  4*DIGITS  result digits.
- bout  output  1  borrow out of the most-significant digit.
- neg  output  1  result is negative (sign-magnitude mode only; else 0).
- invalid  output  1  an operand digit > 9 was seen in this operation.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, done, diff, bout, neg, invalid = 0; internal operands, digit index and borrow = 0.
- Reset mid-operation aborts; no done pulse is issued.
- States:
  - IDLE: start=1 → latch a, b, bin; clear diff, invalid, neg; idx=0; go CALC.
  - CALC: one digit per cycle.
    - t = a[idx] - b[idx] - borrow, 5-bit signed.
    - If t<0: digit = t+10, borrow=1; else digit = t, borrow=0.
    - Write diff[idx]; idx++. After idx=DIGITS-1: bout=borrow; go DONE (or FIX, see optional feature).
  - DONE: done=1 for exactly this cycle. start=1 here behaves as in IDLE (back-to-back allowed); otherwise go IDLE.
- Latency: start sampled at edge 0; done high in cycle DIGITS+1.
- Outputs diff, bout, neg, invalid hold until the next accepted start.
- start while busy is ignored; the operation is unaffected.
- Invalid digits (>9): invalid set sticky for the operation. The digit is still computed by the rule above, so the result is defined but meaningless (e.g. 0xA - 0 = 0xA).
- Without the optional feature, a negative result is in tens-complement: 0000 - 0001 gives diff=9999, bout=1.
- Width rule: internal per-digit arithmetic is 5 bits; result digits are truncated to 4 bits.

Optional Feature:
- BCD_SIGN_MAG_EN defined:
  - If bout=1 at end of CALC, go to state FIX.
  - FIX runs DIGITS further cycles computing 0 - diff with borrow-in 0 (same digit rule). This replaces diff with its magnitude and sets neg=1.
  - bout remains 1. done comes DIGITS cycles later, at cycle 2*DIGITS+1.
  - If bout=0, timing is unchanged.
- Macro undefined: no FIX state; neg tied 0; diff is tens-complement.

Decomposition:
- Package bcd_pkg:
  - BCD_DIGIT_W=4, BCD_MAX=9, BCD_RADIX=10.
  - State enum (IDLE, CALC, FIX, DONE).
  - Digit typedef (4-bit).
- Sub-module bcd_digit_sub: combinational single-digit subtract.
  - Inputs: x, y, bi. Outputs: d, bo, bad (bad = x>9 or y>9).
  - Instantiated once and shared by CALC and FIX.

Test Plan (DIGITS=4):
- a=0x1234, b=0x0567, bin=0 → diff=0x0667, bout=0, invalid=0; done exactly in cycle 5, busy high cycles 1-4.
- a=0x0000, b=0x0001 → without macro: diff=0x9999, bout=1, neg=0, done cycle 5. With BCD_SIGN_MAG_EN: diff=0x0001, bout=1, neg=1, done cycle 9.
- a=0x9999, b=0x9999, bin=1 → diff=0x9999, bout=1. Then a=0x5000, b=0x0001, bin=0 started in the DONE cycle → diff=0x4999, bout=0, done 5 cycles later.
- a=0x00A0, b=0x0000 → invalid=1, diff=0x00A0, bout=0. Next operation a=0x0010, b=0x0005 → invalid=0, diff=0x0005.
- Pulse start at cycles 2 and 3 of a running operation → ignored; single done; result matches the first operands.
- Assert rst_n=0 in cycle 2 of an operation → busy, done, diff, bout, neg, invalid = 0 immediately. After release, no done appears until a new start.
